// File: rtl/ram_test_pkg.sv
// Phase encoding and address helpers shared by the RAM self-test sequencer
// and the board display logic.
package ram_test_pkg;

    typedef enum logic [3:0] {
        PH_IDLE    = 4'd0,
        PH_FILL    = 4'd1,
        PH_CHECK0  = 4'd2,
        PH_COPY_RD = 4'd3,
        PH_COPY_WR = 4'd4,
        PH_CHECK1  = 4'd5,
        PH_DONE    = 4'd6
    } phase_t;

    // Bank select sits directly above the per-bank word address.
    function automatic int bank_bit_pos(input int addr_w);
        return addr_w;
    endfunction

endpackage

// File: rtl/ram_access_port.sv
// Request/done handshake register towards the SRAM controller: holds re/we,
// address and write data from issue until done, then drops for one cycle.
module ram_access_port #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              we,
    input  logic [ADDR_W:0]   addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_done,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              ready,
    output logic              done
);

    logic pending;

    assign pending = mem_re | mem_we;
    assign ready   = !pending;
    assign done    = pending && mem_done;

    // A new issue is only accepted while idle, so the drop cycle after done
    // is always the idle gap between consecutive requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (pending) begin
            if (mem_done) begin
                mem_re <= 1'b0;
                mem_we <= 1'b0;
            end
        end else if (issue) begin
            mem_re    <= !we;
            mem_we    <= we;
            mem_addr  <= addr;
            mem_wdata <= wdata;
        end
    end

endmodule

// File: rtl/ram_bist_sequencer.sv
// RAM self-test sequencer: fill/check bank 0, optionally copy to bank 1 with
// an offset and check it, then report pass/fail, error count and first error.
module ram_bist_sequencer
    import ram_test_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int BURST_LEN   = 10,
    parameter int COPY_OFFSET = 1,
    parameter int ERR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              copy_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] seed,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W:0]   first_err_addr,
    output logic [3:0]        phase,
    output logic [ADDR_W-1:0] index
);

    localparam int                BANK_BIT = bank_bit_pos(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BURST_LEN - 1);
    localparam logic [DATA_W-1:0] OFFSET   = DATA_W'(COPY_OFFSET);

    phase_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, base_q, word;
    logic [DATA_W-1:0] seed_q, copy_q, pattern, expect_d, acc_wdata;
    logic [ADDR_W:0]   acc_addr;
    logic              copy_en_q, last, is_check;
    logic              acc_issue, acc_we, acc_ready, acc_done;

    // Word address wraps inside the bank; the bank bit is never carried into.
    assign word     = base_q + idx;
    assign pattern  = seed_q + DATA_W'(idx);
    assign last     = (idx == LAST_IDX);
    assign is_check = (state == PH_CHECK0) || (state == PH_CHECK1);
    assign phase    = state;
    assign index    = idx;

    ram_access_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_port (
        .clk      (clk),
        .rst      (rst),
        .issue    (acc_issue),
        .we       (acc_we),
        .addr     (acc_addr),
        .wdata    (acc_wdata),
        .mem_done (mem_done),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .ready    (acc_ready),
        .done     (acc_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= PH_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PH_IDLE:    if (start) state_nxt = PH_FILL;
            PH_FILL:    if (acc_done && last) state_nxt = PH_CHECK0;
            PH_CHECK0:  if (acc_done && last) state_nxt = copy_en_q ? PH_COPY_RD : PH_DONE;
            PH_COPY_RD: if (acc_done) state_nxt = PH_COPY_WR;
            PH_COPY_WR: if (acc_done) state_nxt = last ? PH_CHECK1 : PH_COPY_RD;
            PH_CHECK1:  if (acc_done && last) state_nxt = PH_DONE;
            PH_DONE:    state_nxt = PH_IDLE;
            default:    state_nxt = PH_IDLE;
        endcase
    end

    always_comb begin
        acc_issue                = 1'b0;
        acc_we                   = 1'b0;
        acc_addr                 = '0;
        acc_addr[ADDR_W-1:0]     = word;
        acc_wdata                = pattern;
        expect_d                 = pattern;
        case (state)
            PH_FILL: begin
                acc_issue = acc_ready;
                acc_we    = 1'b1;
            end
            PH_CHECK0, PH_COPY_RD: acc_issue = acc_ready;
            PH_COPY_WR: begin
                acc_issue          = acc_ready;
                acc_we             = 1'b1;
                acc_addr[BANK_BIT] = 1'b1;
                acc_wdata          = copy_q;
            end
            PH_CHECK1: begin
                acc_issue          = acc_ready;
                acc_addr[BANK_BIT] = 1'b1;
                expect_d           = pattern - OFFSET;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            base_q         <= '0;
            seed_q         <= '0;
            copy_en_q      <= 1'b0;
            copy_q         <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            busy           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
        end else begin
            case (state)
                PH_IDLE: if (start) begin
                    base_q         <= base_addr;
                    seed_q         <= seed;
                    copy_en_q      <= copy_en;
                    idx            <= '0;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    pass           <= 1'b0;
                    fail           <= 1'b0;
                    busy           <= 1'b1;
                end
                PH_DONE: begin
                    busy <= 1'b0;
                    pass <= (err_count == '0);
                    fail <= (err_count != '0);
                end
                default: if (acc_done) begin
                    // COPY_RD keeps the index so the following write hits the same word.
                    if (state == PH_COPY_RD) copy_q <= mem_rdata - OFFSET;
                    else                     idx    <= last ? '0 : idx + 1'b1;
                    if (is_check && mem_rdata != expect_d) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (err_count == '0) first_err_addr <= mem_addr;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_sequencer.sv
// Randomised scoreboard bench for ram_bist_sequencer with a latency-controlled
// SRAM responder, injectable read faults and a high-level reference model.
module tb_ram_bist_sequencer;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        copy_en = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] seed = '0;
    logic        mem_re, mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        busy, pass, fail;
    logic [1:0]  err_count;
    logic [16:0] first_err_addr;
    logic [3:0]  phase;
    logic [15:0] index;

    ram_bist_sequencer #(
        .DATA_W(16), .ADDR_W(16), .BURST_LEN(N), .COPY_OFFSET(1), .ERR_W(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .copy_en(copy_en),
        .base_addr(base_addr), .seed(seed),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .busy(busy), .pass(pass), .fail(fail), .err_count(err_count),
        .first_err_addr(first_err_addr), .phase(phase), .index(index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pass_v;
        logic        fail_v;
        logic [1:0]  errc;
        logic [16:0] ferr;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    int          lat_q[$];
    logic [15:0] mem   [logic [16:0]];
    logic [15:0] ref_m [logic [16:0]];
    int          total = 0, bad = 0;
    int          cyc = 0, start_cyc = 0;
    int          fault = 0, bank1_writes = 0;
    bit          cur_copy = 0, aborting = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Read path fault: 1 = bit0 stuck high at bank-0 word 0x13, 2 = every read inverted.
    function automatic logic [15:0] fault_rd(input logic [16:0] a, input logic [15:0] v);
        if (fault == 1 && a == 17'h00013) return v | 16'h0001;
        if (fault == 2) return ~v;
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SRAM responder: per-request latency from lat_q, handshake rule checks,
    // garbage rdata outside done, spurious done strobes while idle.
    initial begin
        bit          act = 0, prev_req = 0;
        int          cnt = 0, lat = 1;
        logic [16:0] a_h = '0;
        logic [15:0] d_h = '0;
        logic        we_h = 1'b0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_done  = 1'b0;
            mem_rdata = 16'($urandom);
            if (rst) begin
                act      = 0;
                prev_req = 0;
            end else begin
                if (mem_re || mem_we) begin
                    check("re_we_exclusive", mem_re & mem_we, 0);
                    if (!act) begin
                        check("request_gap", prev_req, 0);
                        act  = 1;
                        cnt  = 0;
                        a_h  = mem_addr;
                        d_h  = mem_wdata;
                        we_h = mem_we;
                        lat  = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                    end else begin
                        check("request_hold", {mem_addr, mem_wdata, mem_we}, {a_h, d_h, we_h});
                        cnt++;
                        if (cnt == lat) begin
                            mem_done = 1'b1;
                            act      = 0;
                            if (we_h) begin
                                mem[a_h] = d_h;
                                if (a_h[16]) bank1_writes++;
                            end else begin
                                mem_rdata = fault_rd(a_h, mem.exists(a_h) ? mem[a_h] : 16'h0);
                            end
                        end
                    end
                end else begin
                    if (act) begin
                        check("request_dropped_early", 1, 0);
                        act = 0;
                    end
                    mem_done = ($urandom_range(0, 3) == 0);
                end
                prev_req = mem_re | mem_we;
            end
        end
    end

    // Monitor: pops the expected result when busy falls and checks outputs.
    initial begin
        bit   pb = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) check("index_range", index < N, 1);
            if (pb && !busy && !rst && !aborting) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pass", pass, e.pass_v);
                    check("fail", fail, e.fail_v);
                    check("err_count", err_count, e.errc);
                    check("first_err_addr", first_err_addr, e.ferr);
                    check("run_length", cyc - start_cyc + 1, e.len);
                    check("phase_idle", phase, 0);
                end
            end
            pb = busy;
        end
    end

    // Reference model: walks the test phases over a shadow memory.
    task automatic launch(input logic [15:0] b, input logic [15:0] s, input bit cp,
                          input int f, input int lmin, input int lmax);
        exp_t        e;
        int          nerr = 0, sum = 0, nacc;
        logic [16:0] a0, a1;
        logic [15:0] r, w;
        fault = f;
        cur_copy = cp;
        mem.delete();
        ref_m.delete();
        lat_q.delete();
        bank1_writes = 0;
        nacc = cp ? 5 * N : 2 * N;
        for (int k = 0; k < nacc; k++) begin
            int l = $urandom_range(lmin, lmax);
            lat_q.push_back(l);
            sum += l + 2;
        end
        e.ferr = '0;
        for (int i = 0; i < N; i++) begin
            w = b + 16'(i);
            ref_m[{1'b0, w}] = s + 16'(i);
        end
        for (int i = 0; i < N; i++) begin
            w = b + 16'(i);
            a0 = {1'b0, w};
            r = fault_rd(a0, ref_m[a0]);
            if (r != s + 16'(i)) begin
                if (nerr == 0) e.ferr = a0;
                nerr++;
            end
        end
        if (cp) begin
            for (int i = 0; i < N; i++) begin
                w = b + 16'(i);
                ref_m[{1'b1, w}] = fault_rd({1'b0, w}, ref_m[{1'b0, w}]) - 16'd1;
            end
            for (int i = 0; i < N; i++) begin
                w = b + 16'(i);
                a1 = {1'b1, w};
                r = fault_rd(a1, ref_m[a1]);
                if (r != s + 16'(i) - 16'd1) begin
                    if (nerr == 0) e.ferr = a1;
                    nerr++;
                end
            end
        end
        e.errc   = (nerr > 3) ? 2'd3 : 2'(nerr);
        e.pass_v = (nerr == 0);
        e.fail_v = (nerr != 0);
        e.len    = sum + 3;
        exp_q.push_back(e);
        @(negedge clk);
        base_addr = b;
        seed      = s;
        copy_en   = cp;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start     = 1'b0;
        base_addr = 16'($urandom);
        seed      = 16'($urandom);
        copy_en   = 1'($urandom_range(0, 1));
        check("busy_rise", busy, 1);
        check("phase_fill", phase, 1);
    endtask

    task automatic finish_run(input bit extra_start);
        int t = 0;
        while (busy && t < 4000) begin
            @(negedge clk);
            t++;
            start = (extra_start && t == 20);
        end
        start = 1'b0;
        check("run_timeout", busy, 0);
        foreach (ref_m[a])
            check("mem_word", mem.exists(a) ? {31'd0, a, mem[a]} : 64'hdead_0000_0000,
                  {31'd0, a, ref_m[a]});
        if (!cur_copy) check("bank1_writes", bank1_writes, 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_mem_re"}, mem_re, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass_fail"}, {pass, fail}, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_first_err"}, first_err_addr, 0);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_index"}, index, 0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        @(negedge clk);

        launch(16'h0010, 16'h0005, 1, 0, 1, 1);       // good memory, fixed L=1
        finish_run(0);
        launch(16'h0010, 16'h0005, 1, 1, 1, 1);       // stuck bit at 0x0013
        finish_run(0);
        launch(16'hFFFE, 16'hFFFF, 1, 0, 1, 2);       // address and data wrap
        finish_run(0);
        launch(16'h0040, 16'h1234, 0, 0, 1, 1);       // no copy, extra start mid-run
        finish_run(1);
        launch(16'h0020, 16'h0100, 1, 2, 1, 3);       // all-bad memory, saturation
        finish_run(0);

        // Reset during a bank-1 write with errors already counted.
        launch(16'h0300, 16'h0050, 1, 2, 1, 3);
        t = 0;
        while (!(phase == 4'd4 && mem_we) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("reach_copy_wr", {phase, mem_we}, {4'd4, 1'b1});
        aborting = 1;
        rst = 1'b1;
        @(negedge clk);
        check_cleared("abort");
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        aborting = 0;
        launch(16'h0300, 16'h0050, 1, 0, 1, 2);
        finish_run(0);

        for (int k = 0; k < 6; k++) begin
            launch(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 1, 5);
            finish_run(0);
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
